// File: rtl/bloom_pkg.sv
// Shared Bloom-filter definitions used by bloom_set, bloom_filter and
// bloom_match_collector.
package bloom_pkg;

  localparam int unsigned KEY_W           = 59;
  localparam int unsigned HASH_W          = 7;
  localparam int unsigned NUM_HASH        = 9;
  localparam int unsigned BLOOM_MATCH_LAT = 1;
  localparam int unsigned BLOOM_TAG_W     = 8;

  // One lookup result: the key's tag and whether the filter reported a hit.
  typedef struct packed {
    logic [BLOOM_TAG_W-1:0] tag;
    logic                   match;
  } bloom_res_t;

endpackage

// File: rtl/bloom_result_fifo.sv
// Synchronous result FIFO with an occupancy count output. The head entry is
// read straight from register storage, so the outputs have no combinational
// path from push/pop. Entries become visible the cycle after they are pushed.
module bloom_result_fifo
  import bloom_pkg::*;
#(
  parameter int unsigned WIDTH = $bits(bloom_res_t),
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;

  // A pop on an empty FIFO is ignored.
  assign pop_ok = pop & (count != '0);
  assign valid  = (count != '0);
  assign head   = mem[rd_ptr];

  // Storage; cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally (power-of-two depth); simultaneous push/pop keeps count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bloom_match_collector.sv
// Collects bloom_set match results: re-aligns each match bit with the tag of
// the key presented MATCH_LAT cycles earlier, buffers {tag, match} in a FIFO,
// issues credits to the key source and keeps hit/miss/drop statistics.
// Optional feature macro: BLOOM_COLLECT_STATS_EN (statistics counters and
// drop flag). Without it the statistics outputs are tied to zero.
module bloom_match_collector
  import bloom_pkg::*;
#(
  parameter int unsigned TAG_W      = BLOOM_TAG_W,
  parameter int unsigned MATCH_LAT  = BLOOM_MATCH_LAT,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             key_valid_i,
  input  logic [TAG_W-1:0] key_tag_i,
  input  logic             match_i,
  output logic             key_ready_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [TAG_W-1:0] res_tag_o,
  output logic             res_match_o,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic             drop_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             match;
  } res_t;

  logic [MATCH_LAT-1:0] dl_valid;
  logic [TAG_W-1:0]     dl_tag [MATCH_LAT];
  logic [CW-1:0]        fifo_count;
  int unsigned          occupancy;
  logic                 accept;
  logic                 drop;
  logic                 push;
  res_t                 push_data;
  res_t                 head;

  // Credit: buffered results plus keys still in the delay line must fit the FIFO.
  always_comb begin
    occupancy = 32'(fifo_count);
    for (int unsigned i = 0; i < MATCH_LAT; i++) occupancy += 32'(dl_valid[i]);
    key_ready_o = (occupancy < FIFO_DEPTH);
  end

  assign accept    = key_valid_i & key_ready_o;
  assign drop      = key_valid_i & ~key_ready_o;
  assign push      = dl_valid[MATCH_LAT-1];
  assign push_data = '{tag: dl_tag[MATCH_LAT-1], match: match_i};

  // Delay line carrying {valid, tag} alongside the bloom_set pipeline.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dl_valid <= '0;
      for (int unsigned i = 0; i < MATCH_LAT; i++) dl_tag[i] <= '0;
    end else begin
      dl_valid[0] <= accept;
      dl_tag[0]   <= key_tag_i;
      for (int unsigned i = 1; i < MATCH_LAT; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_tag[i]   <= dl_tag[i-1];
      end
    end
  end

  bloom_result_fifo #(
    .WIDTH($bits(res_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (push_data),
    .pop       (res_ready_i),
    .head      (head),
    .valid     (res_valid_o),
    .count     (fifo_count)
  );

  assign res_tag_o   = head.tag;
  assign res_match_o = head.match;

`ifdef BLOOM_COLLECT_STATS_EN
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             drop_flag;

  // Saturating statistics; a clear in the same cycle as an increment wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      drop_cnt  <= '0;
      drop_flag <= 1'b0;
    end else if (clr_cnt_i) begin
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      drop_cnt  <= '0;
      drop_flag <= 1'b0;
    end else begin
      if (push &  match_i && !(&hit_cnt))  hit_cnt  <= hit_cnt  + CNT_W'(1);
      if (push & ~match_i && !(&miss_cnt)) miss_cnt <= miss_cnt + CNT_W'(1);
      if (drop && !(&drop_cnt))            drop_cnt <= drop_cnt + CNT_W'(1);
      if (drop)                            drop_flag <= 1'b1;
    end
  end

  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;
  assign drop_cnt_o = drop_cnt;
  assign drop_o     = drop_flag;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt_i;
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
  assign drop_cnt_o = '0;
  assign drop_o     = 1'b0;
`endif

endmodule

// File: tb/tb_bloom_match_collector.sv
// Self-checking bench for bloom_match_collector. A queue-based reference model
// tracks keys awaiting their match bit and the buffered results; statistics
// expectations collapse to zero when BLOOM_COLLECT_STATS_EN is not defined.
module tb_bloom_match_collector;

  localparam int unsigned TAG_W = 8;
  localparam int unsigned LAT   = 1;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 32;
`ifdef BLOOM_COLLECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             key_valid_i;
  logic [TAG_W-1:0] key_tag_i;
  logic             match_i;
  logic             key_ready_o;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [TAG_W-1:0] res_tag_o;
  logic             res_match_o;
  logic             clr_cnt_i;
  logic [CNT_W-1:0] hit_cnt_o;
  logic [CNT_W-1:0] miss_cnt_o;
  logic [CNT_W-1:0] drop_cnt_o;
  logic             drop_o;

  always #5 clk_i = ~clk_i;

  bloom_match_collector #(
    .TAG_W(TAG_W), .MATCH_LAT(LAT), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .key_valid_i(key_valid_i), .key_tag_i(key_tag_i),
    .match_i(match_i), .key_ready_o(key_ready_o), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_tag_o(res_tag_o), .res_match_o(res_match_o),
    .clr_cnt_i(clr_cnt_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o),
    .drop_cnt_o(drop_cnt_o), .drop_o(drop_o)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model: keys waiting for their match bit, and results buffered.
  typedef struct { logic [7:0] tag; int unsigned due; } pend_t;
  typedef struct { logic [7:0] tag; logic match; } res_t;
  pend_t       pend[$];
  res_t        fq[$];
  int unsigned cyc = 0;
  longint unsigned m_hit = 0, m_miss = 0, m_drop = 0;
  logic        m_dropf = 1'b0;

  function automatic bit model_ready();
    return (fq.size() + pend.size()) < DEPTH;
  endfunction

  function automatic void model_reset();
    pend.delete(); fq.delete();
    m_hit = 0; m_miss = 0; m_drop = 0; m_dropf = 1'b0;
  endfunction

  function automatic void model_step(logic kv, logic [7:0] tag, logic m, logic rr, logic clr);
    bit rdy = model_ready();
    if (rr && fq.size() > 0) void'(fq.pop_front());
    if (pend.size() > 0 && pend[0].due == cyc) begin
      fq.push_back('{pend[0].tag, m});
      if (m) m_hit++; else m_miss++;
      void'(pend.pop_front());
    end
    if (kv && rdy) pend.push_back('{tag, cyc + LAT});
    else if (kv) begin m_drop++; m_dropf = 1'b1; end
    if (clr) begin m_hit = 0; m_miss = 0; m_drop = 0; m_dropf = 1'b0; end
    cyc++;
  endfunction

  // Drive one cycle of inputs (at posedge+1), advance the model, move to next posedge+1.
  task automatic drive(input logic kv, input logic [7:0] tag, input logic m,
                       input logic rr, input logic clr);
    key_valid_i = kv; key_tag_i = tag; match_i = m; res_ready_i = rr; clr_cnt_i = clr;
    model_step(kv, tag, m, rr, clr);
    @(posedge clk_i); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((fq.size() > 0 || pend.size() > 0) && n < 40) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); n++;
    end
    tests++;
    if (res_valid_o !== 1'b0 || n >= 40) begin
      fails++;
      $display("FAIL drain: res_valid_o=%b after %0d cycles, required 0 within 40", res_valid_o, n);
    end
  endtask

  task automatic test_reset();
    tests++; if (res_valid_o !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %b, expected 0", res_valid_o); end
    tests++; if (key_ready_o !== 1'b1) begin fails++; $display("FAIL reset_key_ready: got %b, expected 1", key_ready_o); end
    tests++; if (res_tag_o !== 8'h00) begin fails++; $display("FAIL reset_res_tag: got %h, expected 00", res_tag_o); end
    tests++; if (res_match_o !== 1'b0) begin fails++; $display("FAIL reset_res_match: got %b, expected 0", res_match_o); end
    tests++; if (hit_cnt_o !== '0) begin fails++; $display("FAIL reset_hit: got %0d, expected 0", hit_cnt_o); end
    tests++; if (miss_cnt_o !== '0) begin fails++; $display("FAIL reset_miss: got %0d, expected 0", miss_cnt_o); end
    tests++; if (drop_cnt_o !== '0) begin fails++; $display("FAIL reset_drop_cnt: got %0d, expected 0", drop_cnt_o); end
    tests++; if (drop_o !== 1'b0) begin fails++; $display("FAIL reset_drop: got %b, expected 0", drop_o); end
  endtask

  task automatic test_single_key();
    drive(1'b1, 8'h2A, 1'b0, 1'b1, 1'b0);
    tests++; if (res_valid_o !== 1'b0) begin fails++; $display("FAIL single_early: res_valid_o=%b at t+1, expected 0", res_valid_o); end
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    tests++; if (res_valid_o !== 1'b1) begin fails++; $display("FAIL single_valid: got %b, expected 1", res_valid_o); end
    tests++; if (res_tag_o !== 8'h2A) begin fails++; $display("FAIL single_tag: got %h, expected 2a", res_tag_o); end
    tests++; if (res_match_o !== 1'b1) begin fails++; $display("FAIL single_match: got %b, expected 1", res_match_o); end
    tests++; if (hit_cnt_o !== (STATS ? 32'd1 : 32'd0)) begin fails++; $display("FAIL single_hit: got %0d, expected %0d", hit_cnt_o, STATS ? 1 : 0); end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_pressure();
    int got = 0;
    drain();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (key_ready_o !== (i < 8)) begin fails++; $display("FAIL bp_ready[%0d]: got %b, expected %b", i, key_ready_o, (i < 8)); end
      drive(1'b1, 8'(8'h40 + i), 1'($urandom), 1'b0, 1'b0);
    end
    drive(1'b0, 8'h00, 1'($urandom), 1'b0, 1'b0);
    tests++; if (drop_o !== STATS) begin fails++; $display("FAIL bp_drop_flag: got %b, expected %b", drop_o, STATS); end
    tests++; if (drop_cnt_o !== (STATS ? 32'd1 : 32'd0)) begin fails++; $display("FAIL bp_drop_cnt: got %0d, expected %0d", drop_cnt_o, STATS ? 1 : 0); end
    for (int n = 0; n < 20 && got < 8; n++) begin
      if (res_valid_o === 1'b1) begin
        tests++;
        if (res_tag_o !== 8'(8'h40 + got) || res_match_o !== fq[0].match) begin
          fails++; $display("FAIL bp_order[%0d]: got %h/%b, expected %h/%b", got, res_tag_o, res_match_o, 8'(8'h40 + got), fq[0].match);
        end
        got++;
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    tests++; if (got != 8 || res_valid_o !== 1'b0) begin fails++; $display("FAIL bp_count: got %0d results, valid=%b, expected 8 and 0", got, res_valid_o); end
  endtask

  task automatic test_full_push_pop();
    drain();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h80 + i), 1'($urandom), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'($urandom), 1'b0, 1'b0);
    tests++; if (key_ready_o !== 1'b0) begin fails++; $display("FAIL full_ready: got %b, expected 0", key_ready_o); end
    for (int n = 0; n < 24; n++) begin
      tests++;
      if (res_valid_o !== (fq.size() > 0)) begin fails++; $display("FAIL full_valid[%0d]: got %b, expected %b", n, res_valid_o, (fq.size() > 0)); end
      else if (fq.size() > 0) begin
        tests++;
        if (res_tag_o !== fq[0].tag || res_match_o !== fq[0].match) begin
          fails++; $display("FAIL full_head[%0d]: got %h/%b, expected %h/%b", n, res_tag_o, res_match_o, fq[0].tag, fq[0].match);
        end
      end
      drive(model_ready(), 8'(8'hA0 + n), 1'($urandom), 1'b1, 1'b0);
    end
    tests++; if (drop_o !== 1'b0 || drop_cnt_o !== '0) begin fails++; $display("FAIL full_nodrop: drop_o=%b drop_cnt=%0d, expected 0/0", drop_o, drop_cnt_o); end
  endtask

  task automatic test_alternating();
    drain();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    // Key j is presented at cycle j; its match bit arrives LAT cycles later.
    for (int j = 0; j < 100 + LAT; j++)
      drive(1'(j < 100), 8'(j), (j >= LAT) ? 1'(((j - LAT) % 2) == 0) : 1'b0, 1'b1, 1'b0);
    tests++; if (hit_cnt_o !== (STATS ? 32'd50 : 32'd0)) begin fails++; $display("FAIL alt_hit: got %0d, expected %0d", hit_cnt_o, STATS ? 50 : 0); end
    tests++; if (miss_cnt_o !== (STATS ? 32'd50 : 32'd0)) begin fails++; $display("FAIL alt_miss: got %0d, expected %0d", miss_cnt_o, STATS ? 50 : 0); end
    drive(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    tests++; if (hit_cnt_o !== '0 || miss_cnt_o !== '0 || drop_cnt_o !== '0 || drop_o !== 1'b0) begin
      fails++; $display("FAIL clr_wins: hit=%0d miss=%0d drop=%0d flag=%b, expected all 0", hit_cnt_o, miss_cnt_o, drop_cnt_o, drop_o);
    end
    tests++; if (res_valid_o !== 1'b1 || res_tag_o !== 8'hAA || res_match_o !== 1'b1) begin
      fails++; $display("FAIL clr_keeps_fifo: got %b/%h/%b, expected 1/aa/1", res_valid_o, res_tag_o, res_match_o);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    drain();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'hD0, 1'b0, 1'b0, 1'b0);
    key_valid_i = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    model_reset();
    tests++; if (res_valid_o !== 1'b0) begin fails++; $display("FAIL arst_valid: got %b, expected 0", res_valid_o); end
    tests++; if (key_ready_o !== 1'b1) begin fails++; $display("FAIL arst_ready: got %b, expected 1", key_ready_o); end
    tests++; if (res_tag_o !== 8'h00 || res_match_o !== 1'b0) begin fails++; $display("FAIL arst_head: got %h/%b, expected 00/0", res_tag_o, res_match_o); end
    @(posedge clk_i); #2 rst_i = 1'b0;
    @(posedge clk_i); #1;
    drive(1'b1, 8'h5C, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    tests++; if (res_valid_o !== 1'b1 || res_tag_o !== 8'h5C || res_match_o !== 1'b1) begin
      fails++; $display("FAIL arst_post_key: got %b/%h/%b, expected 1/5c/1", res_valid_o, res_tag_o, res_match_o);
    end
    tests++; if (hit_cnt_o !== (STATS ? 32'd1 : 32'd0)) begin fails++; $display("FAIL arst_hit: got %0d, expected %0d", hit_cnt_o, STATS ? 1 : 0); end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      tests++;
      if (res_valid_o !== (fq.size() > 0)) begin fails++; $display("FAIL rnd_valid[%0d]: got %b, expected %b", n, res_valid_o, (fq.size() > 0)); end
      else if (fq.size() > 0) begin
        tests++;
        if (res_tag_o !== fq[0].tag || res_match_o !== fq[0].match) begin
          fails++; $display("FAIL rnd_head[%0d]: got %h/%b, expected %h/%b", n, res_tag_o, res_match_o, fq[0].tag, fq[0].match);
        end
      end
      tests++;
      if (key_ready_o !== model_ready()) begin fails++; $display("FAIL rnd_ready[%0d]: got %b, expected %b", n, key_ready_o, model_ready()); end
      tests++;
      if (hit_cnt_o !== (STATS ? 32'(m_hit) : 32'd0) || miss_cnt_o !== (STATS ? 32'(m_miss) : 32'd0) ||
          drop_cnt_o !== (STATS ? 32'(m_drop) : 32'd0) || drop_o !== (STATS & m_dropf)) begin
        fails++; $display("FAIL rnd_stats[%0d]: got %0d/%0d/%0d/%b, expected %0d/%0d/%0d/%b", n,
                          hit_cnt_o, miss_cnt_o, drop_cnt_o, drop_o,
                          STATS ? m_hit : 0, STATS ? m_miss : 0, STATS ? m_drop : 0, STATS & m_dropf);
      end
      drive(1'(($urandom % 4) != 0), 8'($urandom), 1'($urandom), 1'(($urandom % 3) != 0),
            1'(($urandom % 50) == 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; key_valid_i = 1'b0; key_tag_i = '0; match_i = 1'b0;
    res_ready_i = 1'b0; clr_cnt_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    test_reset();
    test_single_key();
    test_back_pressure();
    test_full_push_pop();
    test_alternating();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
